// File: rtl/ccc_mon_pkg.sv
// Shared types and constants for the MSS clock lock monitor.
package ccc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  // Cycles spent flushing the synchroniser before the first window opens.
  localparam int ARM_CYCLES = 3;

  localparam int FERR_FAST = 1;
  localparam int FERR_SLOW = 0;

endpackage

// File: rtl/ccc_mon_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous strobe.
// A rise on i_async shows up on o_rise as a one-cycle pulse 2-3 cycles later.
module ccc_mon_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ccc_lock_monitor.sv
// Qualifies a CCC-generated clock: counts MON_CLK edges per FAB_CLK window and
// asserts LOCK after LOCK_COUNT consecutive in-tolerance windows.
module ccc_lock_monitor
  import ccc_mon_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int WINDOW_CYCLES = 1000,
  parameter int EXPECTED      = 500,
  parameter int TOLERANCE     = 4,
  parameter int LOCK_COUNT    = 4
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             MON_CLK,
  output logic             LOCK,
  output logic             LOCK_LOST,
  output logic [CNT_W-1:0] MEAS_COUNT,
  output logic             MEAS_VALID,
  output logic [1:0]       FREQ_ERR
);

  localparam logic [CNT_W-1:0]    WIN_LAST    = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]    STREAK_FULL = CNT_W'(LOCK_COUNT);
  localparam logic [1:0]          ARM_LAST    = 2'(ARM_CYCLES - 1);
  // Signed bounds one bit wider than the count so a negative low bound never wraps.
  localparam logic signed [CNT_W:0] LO_BOUND  = (CNT_W + 1)'(EXPECTED - TOLERANCE);
  localparam logic signed [CNT_W:0] HI_BOUND  = (CNT_W + 1)'(EXPECTED + TOLERANCE);

  mon_state_e r_state;
  mon_state_e w_state_nxt;

  logic                    w_edge_p;
  logic [1:0]              r_arm_cnt;
  logic [CNT_W-1:0]        r_win_cnt;
  logic [CNT_W-1:0]        r_edge_cnt;
  logic [CNT_W-1:0]        w_cap;
  logic signed [CNT_W:0]   w_cap_s;
  logic                    w_win_end;
  logic                    w_eval;
  logic                    w_fast;
  logic                    w_slow;
  logic                    w_good;
  logic [CNT_W-1:0]        r_streak;
  logic [CNT_W-1:0]        w_streak_nxt;

  logic                    r_lock;
  logic                    r_lock_lost;
  logic [CNT_W-1:0]        r_meas_count;
  logic                    r_meas_valid;
  logic [1:0]              r_freq_err;

  ccc_mon_sync_edge u_sync (
    .i_clk   (FAB_CLK),
    .i_rst   (RESET),
    .i_async (MON_CLK),
    .o_rise  (w_edge_p)
  );

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!ENABLE) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = ARM;
        ARM:     if (r_arm_cnt == ARM_LAST) w_state_nxt = MEASURE;
        MEASURE: w_state_nxt = MEASURE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET || r_state != ARM) begin
      r_arm_cnt <= 2'd0;
    end else begin
      r_arm_cnt <= r_arm_cnt + 2'd1;
    end
  end

  assign w_win_end = (r_state == MEASURE) && (r_win_cnt == WIN_LAST);
  assign w_eval    = w_win_end && ENABLE;

  // The closing cycle's edge belongs to the window being captured.
  assign w_cap   = (r_edge_cnt == CNT_MAX) ? CNT_MAX : r_edge_cnt + CNT_W'(w_edge_p);
  assign w_cap_s = $signed({1'b0, w_cap});
  assign w_fast  = w_cap_s > HI_BOUND;
  assign w_slow  = w_cap_s < LO_BOUND;
  assign w_good  = !w_fast && !w_slow;

  assign w_streak_nxt = (r_streak >= STREAK_FULL) ? STREAK_FULL : r_streak + 1'b1;

  always_ff @(posedge FAB_CLK) begin
    if (RESET || !ENABLE || r_state != MEASURE || w_win_end) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + 1'b1;
      if (w_edge_p && r_edge_cnt != CNT_MAX) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      r_lock       <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_meas_count <= '0;
      r_meas_valid <= 1'b0;
      r_freq_err   <= 2'b00;
      r_streak     <= '0;
    end else begin
      r_meas_valid <= 1'b0;
      r_lock_lost  <= 1'b0;
      if (!ENABLE) begin
        r_lock     <= 1'b0;
        r_streak   <= '0;
        r_freq_err <= 2'b00;
      end else if (w_eval) begin
        r_meas_count          <= w_cap;
        r_meas_valid          <= 1'b1;
        r_freq_err[FERR_FAST] <= w_fast;
        r_freq_err[FERR_SLOW] <= w_slow;
        if (w_good) begin
          r_streak <= w_streak_nxt;
          if (w_streak_nxt == STREAK_FULL) r_lock <= 1'b1;
        end else begin
          r_streak    <= '0;
          r_lock      <= 1'b0;
          r_lock_lost <= r_lock;
        end
      end
    end
  end

  assign LOCK       = r_lock;
  assign LOCK_LOST  = r_lock_lost;
  assign MEAS_COUNT = r_meas_count;
  assign MEAS_VALID = r_meas_valid;
  assign FREQ_ERR   = r_freq_err;

endmodule

// File: tb/tb_ccc_lock_monitor.sv
// Scoreboard bench for ccc_lock_monitor with 100-cycle windows, 25 +/- 1 edges, 2-window lock.
module tb_ccc_lock_monitor;

  logic        FAB_CLK;
  logic        RESET;
  logic        ENABLE;
  logic        MON_CLK;
  logic        LOCK;
  logic        LOCK_LOST;
  logic [15:0] MEAS_COUNT;
  logic        MEAS_VALID;
  logic [1:0]  FREQ_ERR;

  ccc_lock_monitor #(
    .CNT_W         (16),
    .WINDOW_CYCLES (100),
    .EXPECTED      (25),
    .TOLERANCE     (1),
    .LOCK_COUNT    (2)
  ) dut (
    .FAB_CLK    (FAB_CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .MON_CLK    (MON_CLK),
    .LOCK       (LOCK),
    .LOCK_LOST  (LOCK_LOST),
    .MEAS_COUNT (MEAS_COUNT),
    .MEAS_VALID (MEAS_VALID),
    .FREQ_ERR   (FREQ_ERR)
  );

  typedef struct {
    int         lo;
    int         hi;
    logic [1:0] ferr;
    logic       lock;
    logic       lost;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   errors = 0;

  // MON_CLK generator: period in FAB_CLK cycles, 0 = hands-off (bench drives it directly).
  int mon_per  = 0;
  int skip     = 0;
  int gen_ph   = 0;
  int gen_last = 0;

  initial begin
    FAB_CLK = 1'b0;
    forever #5 FAB_CLK = ~FAB_CLK;
  end

  initial begin
    MON_CLK = 1'b0;
    forever begin
      @(negedge FAB_CLK);
      if (mon_per != gen_last) begin
        gen_ph   = 0;
        gen_last = mon_per;
      end
      if (mon_per > 0) begin
        if (gen_ph == 0) begin
          if (skip > 0) begin
            skip    = skip - 1;
            MON_CLK = 1'b0;
          end else begin
            MON_CLK = 1'b1;
          end
        end else if (gen_ph == mon_per / 2) begin
          MON_CLK = 1'b0;
        end
        gen_ph = (gen_ph + 1 >= mon_per) ? 0 : gen_ph + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int lo, input int hi, input logic [1:0] f,
                      input logic lk, input logic ls);
    exp_t e;
    e.lo   = lo;
    e.hi   = hi;
    e.ferr = f;
    e.lock = lk;
    e.lost = ls;
    q.push_back(e);
  endtask

  task automatic wait_mv(input int bound, output int waited);
    waited = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge FAB_CLK);
      waited++;
      if (MEAS_VALID) return;
    end
    tests++;
    errors++;
    $display("FAIL wait_meas_valid: no MEAS_VALID within %0d cycles", bound);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge FAB_CLK);
  endtask

  // Monitor: every MEAS_VALID pops one expectation from the scoreboard.
  always @(negedge FAB_CLK) begin
    if (MEAS_VALID) begin
      exp_t e;
      tests++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_meas_valid: count=%0d ferr=%b lock=%b lost=%b",
                 MEAS_COUNT, FREQ_ERR, LOCK, LOCK_LOST);
      end else begin
        e = q.pop_front();
        if (int'(MEAS_COUNT) < e.lo || int'(MEAS_COUNT) > e.hi || FREQ_ERR != e.ferr ||
            LOCK != e.lock || LOCK_LOST != e.lost) begin
          errors++;
          $display("FAIL window: got count=%0d ferr=%b lock=%b lost=%b, expected count=%0d..%0d ferr=%b lock=%b lost=%b",
                   MEAS_COUNT, FREQ_ERR, LOCK, LOCK_LOST, e.lo, e.hi, e.ferr, e.lock, e.lost);
        end
      end
    end
  end

  initial begin
    int w;
    int total;

    RESET  = 1'b1;
    ENABLE = 1'b0;
    idle(3);
    check("reset_lock", LOCK, 0);
    check("reset_lock_lost", LOCK_LOST, 0);
    check("reset_meas_valid", MEAS_VALID, 0);
    check("reset_meas_count", MEAS_COUNT, 0);
    check("reset_freq_err", FREQ_ERR, 0);

    // Lock acquisition with a 4-cycle MON_CLK.
    mon_per = 4;
    RESET   = 1'b0;
    idle(8);
    ENABLE = 1'b1;
    push(25, 25, 2'b00, 1'b0, 1'b0);
    push(25, 25, 2'b00, 1'b1, 1'b0);
    push(25, 25, 2'b00, 1'b1, 1'b0);
    wait_mv(120, w);
    total = w;
    wait_mv(120, w);
    total += w;
    tests++;
    if (total < 200 || total > 208) begin
      errors++;
      $display("FAIL lock_latency: got %0d cycles, expected 200..208", total);
    end
    wait_mv(120, w);

    // Tolerance edge: 24 edges keeps lock, 23 drops it.
    idle(20);
    skip = 1;
    push(24, 24, 2'b00, 1'b1, 1'b0);
    wait_mv(120, w);
    idle(20);
    skip = 2;
    push(23, 23, 2'b01, 1'b0, 1'b1);
    wait_mv(120, w);
    push(25, 25, 2'b00, 1'b0, 1'b0);
    push(25, 25, 2'b00, 1'b1, 1'b0);
    wait_mv(120, w);
    wait_mv(120, w);

    // Stopped clock right at a window boundary.
    mon_per = 0;
    MON_CLK = 1'b0;
    push(0, 1, 2'b01, 1'b0, 1'b1);
    push(0, 0, 2'b01, 1'b0, 1'b0);
    wait_mv(120, w);
    tests++;
    if (w > 101) begin
      errors++;
      $display("FAIL stop_lock_lost_latency: got %0d cycles, expected <= 101", w);
    end
    wait_mv(120, w);

    // Re-enable and relock.
    mon_per = 4;
    ENABLE  = 1'b0;
    idle(1);
    ENABLE = 1'b1;
    push(25, 25, 2'b00, 1'b0, 1'b0);
    push(25, 25, 2'b00, 1'b1, 1'b0);
    wait_mv(120, w);
    wait_mv(120, w);

    // Disable on the capture cycle while locked: the evaluation is dropped.
    idle(99);
    ENABLE = 1'b0;
    idle(1);
    check("dis_lock", LOCK, 0);
    check("dis_lock_lost", LOCK_LOST, 0);
    check("dis_meas_valid", MEAS_VALID, 0);
    check("dis_freq_err", FREQ_ERR, 0);
    check("dis_meas_count_held", MEAS_COUNT, 25);
    idle(30);
    ENABLE = 1'b1;
    push(25, 25, 2'b00, 1'b0, 1'b0);
    push(25, 25, 2'b00, 1'b1, 1'b0);
    wait_mv(120, w);
    wait_mv(120, w);

    // Reset at win_cnt=50 while locked and enabled.
    idle(50);
    RESET = 1'b1;
    idle(1);
    check("rst_mid_lock", LOCK, 0);
    check("rst_mid_lock_lost", LOCK_LOST, 0);
    check("rst_mid_meas_valid", MEAS_VALID, 0);
    check("rst_mid_meas_count", MEAS_COUNT, 0);
    check("rst_mid_freq_err", FREQ_ERR, 0);
    RESET = 1'b0;
    push(25, 25, 2'b00, 1'b0, 1'b0);
    push(25, 25, 2'b00, 1'b1, 1'b0);
    wait_mv(120, w);
    wait_mv(120, w);

    // Too fast: 3-cycle period gives 33-34 edges.
    ENABLE  = 1'b0;
    mon_per = 3;
    idle(1);
    check("fast_pre_lock", LOCK, 0);
    ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(33, 34, 2'b10, 1'b0, 1'b0);
      wait_mv(120, w);
    end

    // Window-boundary edge: edge_p lands exactly on win_cnt==99.
    ENABLE  = 1'b0;
    mon_per = 0;
    MON_CLK = 1'b0;
    idle(1);
    ENABLE = 1'b1;
    push(0, 0, 2'b01, 1'b0, 1'b0);
    wait_mv(120, w);
    push(2, 2, 2'b01, 1'b0, 1'b0);
    push(1, 1, 2'b01, 1'b0, 1'b0);
    for (int k = 1; k <= 99; k++) begin
      @(negedge FAB_CLK);
      case (k)
        40: MON_CLK = 1'b1;
        42: MON_CLK = 1'b0;
        97: MON_CLK = 1'b1;
        99: MON_CLK = 1'b0;
        default: ;
      endcase
    end
    wait_mv(5, w);
    for (int k = 1; k <= 12; k++) begin
      @(negedge FAB_CLK);
      if (k == 10) MON_CLK = 1'b1;
      if (k == 12) MON_CLK = 1'b0;
    end
    wait_mv(120, w);

    idle(5);
    check("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
